pi_alu_mc: RTL
==============

# pi_alu_mc

Parametrised multi-cycle successor to the line-follower PI arithmetic unit. It runs one operation per start request: scaled add/subtract with optional saturation, or a signed fixed-point multiply computed serially by shift-add. Operand selection stays upstream in the PI sequencer, which drives `src1`/`src0`, pulses `start` and waits for `done`. Width, saturation width and product scaling are parameters rather than hard-wired 16/12/12.

## Interface
- `W`, 16: datapath width. Multiply operands are the low `W-1` bits of each source.
- `SAT_BITS`, 12: signed width the add/sub result is clamped to when `saturate=1`.
- `FRAC`, 12: right shift applied to the multiply product.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only when `busy=0`.
- `src1`  in  W  addend / multiplicand.
- `src0`  in  W  subtrahend-addend / multiplier.
- `sub`  in  1  compute `src1 - scaled src0`.
- `mult2`  in  1  scale `src0` by 2 (add path only).
- `mult4`  in  1  scale `src0` by 4 (add path only).
- `saturate`  in  1  clamp the add/sub result to `SAT_BITS` signed.
- `multiply`  in  1  select the multiply path; `sub`/`mult2`/`mult4`/`saturate` are then ignored.
- `busy`  out  1  multiply in progress.
- `done`  out  1  one-cycle pulse; `dst` and `sat_flag` are valid and held until the next `done`.
- `dst`  out  W  result.
- `sat_flag`  out  1  the result of the last op was clamped.

## Operation
- All operands and controls are registered at the accepting edge. Input changes after that edge have no effect.
- **Add path**
  - Scaling: `s = src0<<1` if `mult2` (which wins over `mult4`), `src0<<2` if `mult4`, else `src0`. Bits shifted out are discarded; the result is W bits.
  - Sum: `sum = src1 + (sub ? ~s + 1 : s)`, modulo 2^W.
  - With `saturate=0`: `dst = sum` and `sat_flag=0`.
  - With `saturate=1`, `sum` is treated as signed W:
    - Above `2^(SAT_BITS-1)-1`, `dst` is that maximum.
    - Below `-2^(SAT_BITS-1)`, `dst` is that minimum.
    - Otherwise `dst = sum`.
    - `dst` is always sign-extended to W. `sat_flag=1` if and only if a clamp occurred.
- **Multiply path**
  - Operands: `a = src1[W-2:0]`, `b = src0[W-2:0]`, both signed.
  - Exact product: `P = a*b` (2W-2 bits). Then `R = P >>> FRAC`, an arithmetic shift (floor).
  - Clamp R to `[-2^(W-2), 2^(W-2)-1]` and sign-extend to W. `sat_flag=1` if and only if a clamp occurred.
  - Implementation is serial: sign-magnitude shift-add, one magnitude bit per cycle, with the sign applied before the shift and clamp. The result must be bit-exact to the formula above for all inputs, including `a` or `b` equal to `-2^(W-2)`.
- **FSM states**
  - IDLE
    - `start & ~multiply`: compute the add path, register `dst`/`sat_flag`, assert `done`; stay in IDLE.
    - `start & multiply`: load magnitudes and sign, set the bit counter to `W-2`, clear the accumulator, go to MUL.
  - MUL: add the shifted multiplicand if the current multiplier bit is set, decrement the counter. When the counter is 0, go to FIN.
  - FIN: apply the sign, shift, clamp; register `dst`/`sat_flag`, assert `done`; go to IDLE.
- `start` while `busy=1` is ignored: no queueing, no effect on the op in flight.
- `rst` at any point, including mid-MUL, aborts the op. The next state is IDLE with the accumulator cleared.

## Timing
- Reset values: `busy=0`, `done=0`, `dst=0`, `sat_flag=0`, state IDLE.
- Cycle numbering: edge E0 accepts `start`.
- Add/sub latency is 1.
  - `dst`/`sat_flag` update at E0.
  - `done=1` for the cycle after E0. `busy` stays 0.
- Multiply latency is W (16 at default W).
  - `busy=1` from E0 to E(W).
  - MUL occupies W-1 cycles and FIN occupies 1.
  - `dst`/`sat_flag` update at E(W). `done=1` for the cycle after E(W), and `busy` falls at E(W).
- Back-to-back:
  - `start` during a `done` cycle is accepted, so there are no dead cycles.
  - Add ops can issue on every cycle.
- `done` is never high for two consecutive cycles from a single op.

## Test plan
Default parameters W=16, SAT_BITS=12, FRAC=12.
- Plain add: `src1=0x0100`, `src0=0x0023`, all flags 0. Required: `dst=0x0123`, `sat_flag=0`, `done` one cycle after E0, `busy` never high.
- Saturated sub: `src1=0x0000`, `src0=0x0900`, `sub=1`, `saturate=1`. Required: `dst=0xF800`, `sat_flag=1`.
- Saturated add with mult4: `src1=0x0600`, `src0=0x0100`, `mult4=1`, `saturate=1`. Required: `dst=0x07FF`, `sat_flag=1`.
- Same operands with `mult2=1` and `mult4=1`, `saturate=0`. Required: `dst=0x0800` (mult2 wins), `sat_flag=0`.
- Multiply: `0x1000 * 0x0800`. Required: `dst=0x0800`, `sat_flag=0`, `busy` high exactly 16 cycles, `done` the cycle after E16.
- Multiply: `0x7000 * 0x0800`. Required: `dst=0xF800`.
- Multiply: `0x3FFF * 0x3FFF`. Required: `dst=0x3FFF`, `sat_flag=1`.
- Multiply: `0x4000 * 0x4000`. Required: `dst=0x3FFF`, `sat_flag=1`.
- Start while busy: `start` with add operands at E5 during a multiply. Required: ignored; the multiply result is unchanged and there is exactly one `done`.
- Back-to-back: an add `start` in the multiply's `done` cycle. Required: accepted, its `done` follows one cycle later.
- Reset mid-multiply: `rst` at E6 of a multiply. Required:
  - Next cycle: `busy=0`, `done=0`, `dst=0`, `sat_flag=0`.
  - No `done` is produced for the aborted multiply.
  - A following add `0x0001 + 0x0001` gives `dst=0x0002` with normal latency.

Source files
------------

// File: rtl/pi_alu_mc.sv
// PI arithmetic unit: single-cycle scaled add/sub with optional clamp, or a
// serial sign-magnitude shift-add fixed-point multiply.
module pi_alu_mc #(
  parameter int W        = 16,
  parameter int SAT_BITS = 12,
  parameter int FRAC     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] src1,
  input  logic [W-1:0] src0,
  input  logic         sub,
  input  logic         mult2,
  input  logic         mult4,
  input  logic         saturate,
  input  logic         multiply,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] dst,
  output logic         sat_flag
);

  localparam int AW = 2*W - 2;
  localparam int PW = 2*W;
  localparam int CW = $clog2(W);

  localparam logic [W-1:0]          ONE   = W'(1);
  localparam logic [W-2:0]          ONE1  = (W-1)'(1);
  localparam logic signed [W-1:0]   SMAX  = W'((1 << (SAT_BITS-1)) - 1);
  localparam logic signed [W-1:0]   SMIN  = ~SMAX;
  localparam logic signed [PW-1:0]  MMAX  = (PW'(1) << (W-2)) - PW'(1);
  localparam logic signed [PW-1:0]  MMIN  = ~MMAX;

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;
  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic [AW-1:0] acc, mcand;
  logic [W-2:0]  mplier;
  logic          neg;

  logic [W-1:0]  scaled, sum, add_dst;
  logic          add_sat;
  logic [W-2:0]  a_mag, b_mag;
  logic signed [PW-1:0] mag_ext, prod, shr;
  logic [W-1:0]  mul_dst;
  logic          mul_sat;

  assign busy = (state != IDLE);

  always_comb begin
    if (mult2)      scaled = src0 << 1;
    else if (mult4) scaled = src0 << 2;
    else            scaled = src0;
    sum     = src1 + (sub ? (~scaled + ONE) : scaled);
    add_dst = sum;
    add_sat = 1'b0;
    if (saturate) begin
      if ($signed(sum) > SMAX) begin
        add_dst = SMAX;
        add_sat = 1'b1;
      end else if ($signed(sum) < SMIN) begin
        add_dst = SMIN;
        add_sat = 1'b1;
      end
    end
  end

  always_comb begin
    a_mag = src1[W-2] ? (~src1[W-2:0] + ONE1) : src1[W-2:0];
    b_mag = src0[W-2] ? (~src0[W-2:0] + ONE1) : src0[W-2:0];
  end

  // Sign goes on before the arithmetic shift so negative products floor correctly.
  always_comb begin
    mag_ext = PW'(acc);
    prod    = neg ? -mag_ext : mag_ext;
    shr     = prod >>> FRAC;
    mul_dst = shr[W-1:0];
    mul_sat = 1'b0;
    if (shr > MMAX) begin
      mul_dst = MMAX[W-1:0];
      mul_sat = 1'b1;
    end else if (shr < MMIN) begin
      mul_dst = MMIN[W-1:0];
      mul_sat = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start && multiply) state_nx = MUL;
      MUL:     if (cnt == '0) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      neg      <= 1'b0;
      dst      <= '0;
      sat_flag <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (multiply) begin
              mcand  <= AW'(a_mag);
              mplier <= b_mag;
              neg    <= src1[W-2] ^ src0[W-2];
              cnt    <= CW'(W-2);
              acc    <= '0;
            end else begin
              dst      <= add_dst;
              sat_flag <= add_sat;
              done     <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
        end
        FIN: begin
          dst      <= mul_dst;
          sat_flag <= mul_sat;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
